// File: rtl/fpa_issue_ctrl.sv
// fpa_issue_ctrl: issue/collect stage around a combinational FP32 adder, with IEEE special-case bypass.
// Latency: special operands 1 cycle accept->out_valid; ordinary operands 1+SETTLE_CYCLES cycles.
// Backpressure: one op in flight; in_ready low until result taken; result held while out_ready low.
module fpa_issue_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_x,
   input  logic [31:0] in_y,
   output logic [31:0] fpa_x,
   output logic [31:0] fpa_y,
   input  logic [31:0] fpa_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [2:0]  out_flags
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [3:0] LP_LAST = 4'(SETTLE_CYCLES - 1);
   localparam logic [31:0] LP_QNAN = 32'h7FC0_0000;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic [31:0] r_fpa_x;
   logic [31:0] r_fpa_y;
   logic [31:0] r_result;
   logic [2:0]  r_flags;

   logic        w_accept;
   logic        w_capture;

   // operand classification terms
   logic        w_x_exp_max;
   logic        w_y_exp_max;
   logic        w_x_man_nz;
   logic        w_y_man_nz;
   logic        w_x_nan;
   logic        w_y_nan;
   logic        w_x_inf;
   logic        w_y_inf;
   logic        w_x_zero;
   logic        w_y_zero;
   logic        w_opp_sign;
   logic        w_mag_eq;
   logic        w_special;
   logic [31:0] w_spec_result;
   logic [2:0]  w_spec_flags;

   assign w_x_exp_max = &in_x[30:23];
   assign w_y_exp_max = &in_y[30:23];
   assign w_x_man_nz  = |in_x[22:0];
   assign w_y_man_nz  = |in_y[22:0];
   assign w_x_nan     = w_x_exp_max & w_x_man_nz;
   assign w_y_nan     = w_y_exp_max & w_y_man_nz;
   assign w_x_inf     = w_x_exp_max & ~w_x_man_nz;
   assign w_y_inf     = w_y_exp_max & ~w_y_man_nz;
   // denormals are flushed: any zero exponent is treated as zero
   assign w_x_zero    = ~|in_x[30:23];
   assign w_y_zero    = ~|in_y[30:23];
   assign w_opp_sign  = in_x[31] ^ in_y[31];
   assign w_mag_eq    = (in_x[30:0] == in_y[30:0]);

   // Special-case resolution, highest priority first; anything unmatched goes to the adder.
   always_comb begin
      w_special     = 1'b1;
      w_spec_result = 32'h0000_0000;
      w_spec_flags  = 3'b100;
      if (w_x_nan | w_y_nan) begin
         w_spec_result = LP_QNAN;
         w_spec_flags  = 3'b101;
      end else if (w_x_inf & w_y_inf & w_opp_sign) begin
         w_spec_result = LP_QNAN;
         w_spec_flags  = 3'b101;
      end else if (w_x_inf | w_y_inf) begin
         // both infinite here implies same sign, so X is the right answer
         w_spec_result = w_x_inf ? in_x : in_y;
         w_spec_flags  = 3'b110;
      end else if (w_x_zero & w_y_zero) begin
         w_spec_result = {in_x[31] & in_y[31], 31'b0};
      end else if (w_x_zero) begin
         w_spec_result = in_y;
      end else if (w_y_zero) begin
         w_spec_result = in_x;
      end else if (w_mag_eq & w_opp_sign) begin
         w_spec_result = 32'h0000_0000;
      end else begin
         w_special     = 1'b0;
         w_spec_flags  = 3'b000;
      end
   end

   // State and settle counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic plus accept/capture strobes for the datapath.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_accept = 1'b1;
               if (w_special) begin
                  w_state_nxt = HOLD;
               end else begin
                  w_cnt_nxt   = 4'd0;
                  w_state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == LP_LAST) begin
               w_capture   = 1'b1;
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Operand and result registers; operands only move on accept so the adder sees stable inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fpa_x  <= 32'h0000_0000;
         r_fpa_y  <= 32'h0000_0000;
         r_result <= 32'h0000_0000;
         r_flags  <= 3'b000;
      end else begin
         if (w_accept) begin
            r_fpa_x <= in_x;
            r_fpa_y <= in_y;
            if (w_special) begin
               r_result <= w_spec_result;
               r_flags  <= w_spec_flags;
            end
         end
         if (w_capture) begin
            r_result <= fpa_result;
            r_flags  <= 3'b000;
         end
      end
   end

   assign in_ready   = (r_state == IDLE) & ~rst;
   assign out_valid  = (r_state == HOLD);
   assign fpa_x      = r_fpa_x;
   assign fpa_y      = r_fpa_y;
   assign out_result = r_result;
   assign out_flags  = r_flags;

endmodule

// File: tb/tb_fpa_issue_ctrl.sv
// tb_fpa_issue_ctrl: drives two instances (settle 1 and settle 3) against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: exercises stalled out_ready and ignored in_valid while busy.
module tb_fpa_issue_ctrl;

   localparam int ST0 = 1;
   localparam int ST1 = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_x = 32'h0;
   logic [31:0] in_y = 32'h0;
   int          sel = 0;
   bit          chk_en = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic        iv   [2];
   logic        ordy [2];
   logic        ir   [2];
   logic        ov   [2];
   logic [31:0] fx   [2];
   logic [31:0] fy   [2];
   logic [31:0] fres [2];
   logic [31:0] ores [2];
   logic [2:0]  oflg [2];

   // model state
   bit          m_busy  [2];
   bit          m_valid [2];
   logic [31:0] m_res   [2];
   logic [2:0]  m_flg   [2];
   logic [31:0] m_fx    [2];
   logic [31:0] m_fy    [2];
   int          m_left  [2];
   int          since   [2];

   always #5 clk = ~clk;

   function automatic int settle(input int k);
      return (k == 0) ? ST0 : ST1;
   endfunction

   // Stand-in adder: exact for the 1.0+2.0 vector, a fixed scramble otherwise.
   function automatic logic [31:0] adder(input logic [31:0] x, input logic [31:0] y);
      if (x == 32'h3F80_0000 && y == 32'h4000_0000) return 32'h4040_0000;
      return x ^ {y[15:0], y[31:16]} ^ 32'h1;
   endfunction

   // Returns {special, flags, result} from the IEEE special-case rules.
   function automatic logic [35:0] spec_class(input logic [31:0] x, input logic [31:0] y);
      bit xn, yn, xi, yi, xz, yz;
      xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
      yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
      xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
      yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
      xz = (x[30:23] == 8'h00);
      yz = (y[30:23] == 8'h00);
      if (xn || yn)                          return {1'b1, 3'b101, 32'h7FC0_0000};
      if (xi && yi && (x[31] != y[31]))      return {1'b1, 3'b101, 32'h7FC0_0000};
      if (xi)                                return {1'b1, 3'b110, x};
      if (yi)                                return {1'b1, 3'b110, y};
      if (xz && yz)                          return {1'b1, 3'b100, x[31] & y[31], 31'b0};
      if (xz)                                return {1'b1, 3'b100, y};
      if (yz)                                return {1'b1, 3'b100, x};
      if (x[30:0] == y[30:0] && x[31] != y[31]) return {1'b1, 3'b100, 32'h0};
      return {1'b0, 3'b000, 32'h0};
   endfunction

   assign iv[0]   = in_valid && (sel == 0);
   assign iv[1]   = in_valid && (sel == 1);
   assign ordy[0] = out_ready && (sel == 0);
   assign ordy[1] = out_ready && (sel == 1);
   // adder output is garbage until the operands have been held long enough
   assign fres[0] = (since[0] >= ST0 - 1) ? adder(fx[0], fy[0]) : 32'hDEAD_BEEF;
   assign fres[1] = (since[1] >= ST1 - 1) ? adder(fx[1], fy[1]) : 32'hDEAD_BEEF;

   fpa_issue_ctrl #(.SETTLE_CYCLES(ST0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .in_x(in_x), .in_y(in_y), .fpa_x(fx[0]), .fpa_y(fy[0]),
      .fpa_result(fres[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
      .out_result(ores[0]), .out_flags(oflg[0])
   );

   fpa_issue_ctrl #(.SETTLE_CYCLES(ST1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .in_x(in_x), .in_y(in_y), .fpa_x(fx[1]), .fpa_y(fy[1]),
      .fpa_result(fres[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
      .out_result(ores[1]), .out_flags(oflg[1])
   );

   // Transaction model: one op in flight, result appears after its latency, held until taken.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_busy[k]  <= 1'b0;
            m_valid[k] <= 1'b0;
            m_res[k]   <= 32'h0;
            m_flg[k]   <= 3'b000;
            m_fx[k]    <= 32'h0;
            m_fy[k]    <= 32'h0;
            m_left[k]  <= 0;
            since[k]   <= 0;
         end else if (!m_busy[k]) begin
            if (in_valid && sel == k) begin
               m_busy[k] <= 1'b1;
               m_fx[k]   <= in_x;
               m_fy[k]   <= in_y;
               since[k]  <= 0;
               if (spec_class(in_x, in_y)[35]) begin
                  m_valid[k] <= 1'b1;
                  m_res[k]   <= spec_class(in_x, in_y)[31:0];
                  m_flg[k]   <= spec_class(in_x, in_y)[34:32];
               end else begin
                  m_left[k] <= settle(k);
               end
            end else if (since[k] < 100) begin
               since[k] <= since[k] + 1;
            end
         end else begin
            if (since[k] < 100) since[k] <= since[k] + 1;
            if (m_valid[k]) begin
               if (out_ready && sel == k) begin
                  m_valid[k] <= 1'b0;
                  m_busy[k]  <= 1'b0;
               end
            end else if (m_left[k] > 1) begin
               m_left[k] <= m_left[k] - 1;
            end else begin
               m_left[k]  <= 0;
               m_valid[k] <= 1'b1;
               m_res[k]   <= adder(m_fx[k], m_fy[k]);
               m_flg[k]   <= 3'b000;
            end
         end
      end
   end

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] got=%h want=%h t=%0t", nm, k, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
               chk("in_ready", k, 32'(ir[k]), 32'(!m_busy[k] && !rst));
               chk("out_valid", k, 32'(ov[k]), 32'(m_valid[k]));
               chk("fpa_x", k, fx[k], m_fx[k]);
               chk("fpa_y", k, fy[k], m_fy[k]);
               if (m_valid[k]) begin
                  chk("out_result", k, ores[k], m_res[k]);
                  chk("out_flags", k, 32'(oflg[k]), 32'(m_flg[k]));
               end
            end
         end
      end
   end

   // One transaction with literal expectations; called just after a rising edge with the DUT idle.
   task automatic xact(input int k, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_r, input logic [2:0] exp_f, input int exp_lat);
      int n;
      bit got;
      sel = k;
      in_x = x;
      in_y = y;
      in_valid = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(posedge clk);
         #2;
         in_valid = 1'b0;
         n++;
         @(negedge clk);
         if (ov[k]) got = 1'b1;
      end
      chk("latency", k, got ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_lat));
      chk("lit_result", k, ores[k], exp_r);
      chk("lit_flags", k, 32'(oflg[k]), 32'(exp_f));
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      out_ready = 1'b0;
   endtask

   initial begin
      repeat (2) begin
         @(posedge clk);
         #2;
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_in_ready", k, 32'(ir[k]), 32'd0);
         chk("rst_out_valid", k, 32'(ov[k]), 32'd0);
         chk("rst_out_result", k, ores[k], 32'h0);
         chk("rst_out_flags", k, 32'(oflg[k]), 32'd0);
         chk("rst_fpa_x", k, fx[k], 32'h0);
         chk("rst_fpa_y", k, fy[k], 32'h0);
      end
      chk_en = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;

      // settle 1: normal, zero, infinities, NaN, cancellation, signed zero, denormal flush
      xact(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 2);
      xact(0, 32'h0000_0000, 32'h40A0_0000, 32'h40A0_0000, 3'b100, 1);
      xact(0, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 3'b101, 1);
      xact(0, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 3'b110, 1);
      xact(0, 32'h7FC0_0001, 32'h1234_5678, 32'h7FC0_0000, 3'b101, 1);
      xact(0, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 3'b100, 1);
      xact(0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 3'b100, 1);
      xact(0, 32'h4000_0000, 32'h0040_0000, 32'h4000_0000, 3'b100, 1);
      xact(0, 32'hFF80_0000, 32'hFF80_0000, 32'hFF80_0000, 3'b110, 1);
      xact(0, 32'h4000_0000, 32'h3F80_0000, 32'h4000_3F81, 3'b000, 2);

      // stalled downstream: result held, new requests ignored
      sel = 0;
      in_x = 32'h3F80_0000;
      in_y = 32'h4000_0000;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_x = 32'h0000_0000;
         in_y = 32'h3F80_0000;
         @(negedge clk);
         chk("hold_in_ready", 0, 32'(ir[0]), 32'd0);
         chk("hold_valid", 0, 32'(ov[0]), 32'd1);
         chk("hold_result", 0, ores[0], 32'h4040_0000);
         chk("hold_flags", 0, 32'(oflg[0]), 32'd0);
         @(posedge clk);
         #2;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      out_ready = 1'b0;
      @(negedge clk);
      chk("post_hold_in_ready", 0, 32'(ir[0]), 32'd1);
      xact(0, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b100, 1);

      // settle 3: garbage on the adder until the window closes
      xact(1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 3'b000, 4);
      xact(1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 3'b100, 1);

      // reset while in ISSUE aborts the operation
      sel = 1;
      in_x = 32'h3F80_0000;
      in_y = 32'h4000_0000;
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_valid", 1, 32'(ov[1]), 32'd0);
      chk("abort_fpa_x", 1, fx[1], 32'h0);
      chk("abort_in_ready", 1, 32'(ir[1]), 32'd1);
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_result", 1, 32'(ov[1]), 32'd0);
      end

      @(posedge clk);
      #2;
      xact(1, 32'h4000_0000, 32'h3F80_0000, 32'h4000_3F81, 3'b000, 4);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
